// File: rtl/regbank_write_ctrl_pkg.sv
// Shared definitions for the C0 register-bank write controller: op codes,
// bank source-select codes, FSM state encoding and instruction field helpers.
package regbank_write_ctrl_pkg;

  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_MOV = 2'b01;
  localparam logic [1:0] OP_ALU = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  localparam logic [1:0] MS_ALU  = 2'b00;
  localparam logic [1:0] MS_REG  = 2'b01;
  localparam logic [1:0] MS_IMM  = 2'b10;
  localparam logic [1:0] MS_ZERO = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_IMM_WAIT = 2'b01,
    ST_ALU_WAIT = 2'b10,
    ST_WRITE    = 2'b11
  } state_e;

  // Instruction byte layout: [7:6] op, [5:3] Rd, [2:0] Rs
  function automatic logic [1:0] instr_op(input logic [7:0] b);
    return b[7:6];
  endfunction

  function automatic logic [2:0] instr_rd(input logic [7:0] b);
    return b[5:3];
  endfunction

  function automatic logic [2:0] instr_rs(input logic [7:0] b);
    return b[2:0];
  endfunction

endpackage

// File: rtl/regbank_write_ctrl_timeout.sv
// ALU-wait timeout counter with clear, enable and terminal-count output.
// Only compiled when REGBANK_TIMEOUT_EN is defined; otherwise this file is empty.
`ifdef REGBANK_TIMEOUT_EN
module c0_timeout_ctr #(
  parameter int CNT_W    = 5,
  parameter int TERMINAL = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [CNT_W-1:0] count;

  // Clear wins over enable so a fresh ALU wait always starts from zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end else begin
      count <= count;
    end
  end

  assign tc = (count == CNT_W'(TERMINAL));

endmodule
`endif

// File: rtl/regbank_write_ctrl.sv
// Write sequencer for the C0 8x8 register bank: decodes LDI/MOV/ALU/CLR and
// drives MS/RS/SRC_SEL/IMM/E. Optional ALU timeout enabled by REGBANK_TIMEOUT_EN.
module regbank_write_ctrl
  import regbank_write_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] INSTR,
  input  logic       IVALID,
  output logic       IREADY,
  input  logic       ALU_DONE,
  output logic       ALU_START,
  output logic       MS1,
  output logic       MS0,
  output logic       RS2,
  output logic       RS1,
  output logic       RS0,
  output logic [2:0] SRC_SEL,
  output logic [7:0] IMM,
  output logic       E,
  output logic       BUSY,
  output logic       ERR
);

  if (2**CNT_W <= TIMEOUT_CYCLES) begin : g_bad_cnt_w
    $error("regbank_write_ctrl: CNT_W too narrow for TIMEOUT_CYCLES");
  end

  state_e     state;
  logic [1:0] ms;
  logic [2:0] rs;
  logic [2:0] rd;
  logic [2:0] src_sel;
  logic [7:0] imm;
  logic       iready;
  logic       e;
  logic       alu_start;
  logic       busy;
  logic       transfer;
  logic       abort;

  assign transfer = IVALID & iready;

`ifdef REGBANK_TIMEOUT_EN
  logic tmo_tc;
  logic err;

  c0_timeout_ctr #(
    .CNT_W    (CNT_W),
    .TERMINAL (TIMEOUT_CYCLES - 1)
  ) u_timeout (
    .clk    (CLK),
    .rst    (RST),
    .clear  (transfer && (state == ST_IDLE) && (instr_op(INSTR) == OP_ALU)),
    .enable (state == ST_ALU_WAIT),
    .tc     (tmo_tc)
  );

  // ALU_DONE in the expiry cycle still completes the write
  assign abort = (state == ST_ALU_WAIT) & tmo_tc & ~ALU_DONE;

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      err <= 1'b0;
    end else if (abort) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end

  assign ERR = err;
`else
  assign abort = 1'b0;
  assign ERR   = 1'b0;
`endif

  // Main sequencer; bank-facing fields only change on entry to WRITE so they hold in IDLE
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      iready    <= 1'b0;
      e         <= 1'b0;
      alu_start <= 1'b0;
      ms        <= MS_ALU;
      rs        <= 3'd0;
      rd        <= 3'd0;
      src_sel   <= 3'd0;
      imm       <= 8'h00;
      busy      <= 1'b0;
    end else begin
      e         <= 1'b0;
      alu_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (transfer) begin
            iready <= 1'b0;
            busy   <= 1'b1;
            rd     <= instr_rd(INSTR);
            case (instr_op(INSTR))
              OP_LDI: state <= ST_IMM_WAIT;
              OP_MOV: begin
                state   <= ST_WRITE;
                ms      <= MS_REG;
                src_sel <= instr_rs(INSTR);
                rs      <= instr_rd(INSTR);
                e       <= 1'b1;
              end
              OP_ALU: begin
                state     <= ST_ALU_WAIT;
                alu_start <= 1'b1;
              end
              default: begin
                state <= ST_WRITE;
                ms    <= MS_ZERO;
                rs    <= instr_rd(INSTR);
                e     <= 1'b1;
              end
            endcase
          end else begin
            iready <= 1'b1;
          end
        end
        ST_IMM_WAIT: begin
          if (transfer) begin
            iready <= 1'b0;
            imm    <= INSTR;
            ms     <= MS_IMM;
            rs     <= rd;
            e      <= 1'b1;
            state  <= ST_WRITE;
          end else begin
            iready <= 1'b1;
          end
        end
        ST_ALU_WAIT: begin
          if (ALU_DONE) begin
            ms    <= MS_ALU;
            rs    <= rd;
            e     <= 1'b1;
            state <= ST_WRITE;
          end else if (abort) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            state <= ST_ALU_WAIT;
          end
        end
        ST_WRITE: begin
          iready <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          iready <= 1'b0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

  assign IREADY    = iready;
  assign ALU_START = alu_start;
  assign {MS1, MS0} = ms;
  assign {RS2, RS1, RS0} = rs;
  assign SRC_SEL   = src_sel;
  assign IMM       = imm;
  assign E         = e;
  assign BUSY      = busy;

endmodule
